// File: rtl/button_pulse_array.sv
// N-channel push-button front end: synchroniser, debouncer and edge detector per channel.
// Optional auto-repeat for rise-mode pulses is built only when AUTOREPEAT_EN is defined.
module button_pulse_array #(
  parameter int N             = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 16,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_raw,
  input  logic         enable,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);

  localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);

  if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_pulse_array: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [N-1:0]                  level_q, level_d;
  logic [N-1:0]                  pulse_q, pulse_d;
  logic [N-1:0]                  sync_out;
  logic [N-1:0]                  edge_hit;
  logic [N-1:0]                  rpt_hit;

  always_comb begin
    sync_d[0] = in_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // A new value is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < N; i++) begin
      if (sync_out[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
        level_d[i] = sync_out[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < N; i++) begin
      case (EDGE_MODE)
        0:       edge_hit[i] = ~level_q[i] &  level_d[i];
        1:       edge_hit[i] =  level_q[i] & ~level_d[i];
        default: edge_hit[i] =  level_q[i] ^  level_d[i];
      endcase
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);

  logic [N-1:0][RW-1:0] rpt_q, rpt_d;

  // Down-counter per channel: loaded on press, fires at zero and reloads with the period.
  always_comb begin
    rpt_d   = rpt_q;
    rpt_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (EDGE_MODE != 0 || !level_d[i]) begin
        rpt_d[i] = '0;
      end else if (!level_q[i]) begin
        rpt_d[i] = RW'(REPEAT_DELAY - 1);
      end else if (rpt_q[i] == '0) begin
        rpt_hit[i] = 1'b1;
        rpt_d[i]   = RW'(REPEAT_PERIOD - 1);
      end else begin
        rpt_d[i] = rpt_q[i] - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_hit = '0;
`endif

  assign pulse_d = enable ? (edge_hit | rpt_hit) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level     = level_q;
  assign pulse     = pulse_q;
  assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_button_pulse_array.sv
// Directed bench for button_pulse_array: default rise-mode instance plus a both-edges instance.
module tb_button_pulse_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] in_raw;
  logic       enable;
  logic [4:0] level;
  logic [4:0] pulse;
  logic       any_pulse;

  logic [4:0] in_raw2;
  logic [4:0] level2;
  logic [4:0] pulse2;
  logic       any_pulse2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pcnt [5];
  int p2cnt = 0;
  int p2first = 0;
  int p2second = 0;
  int start2 = 0;
  logic lvl2_seen = 1'b0;
`ifdef AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  button_pulse_array dut (
    .clk(clk), .rst(rst), .in_raw(in_raw), .enable(enable),
    .level(level), .pulse(pulse), .any_pulse(any_pulse)
  );

  button_pulse_array #(.EDGE_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .in_raw(in_raw2), .enable(1'b1),
    .level(level2), .pulse(pulse2), .any_pulse(any_pulse2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 5; i++) pcnt[i] += int'(pulse[i]);
    if (level[2]) lvl2_seen = 1'b1;
    if (pulse2[0]) begin
      p2cnt++;
      if (p2cnt == 1) p2first = cyc;
      else p2second = cyc;
    end
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 5; i++) pcnt[i] = 0;
  endtask

  initial begin
    rst     = 1'b1;
    in_raw  = '0;
    in_raw2 = '0;
    enable  = 1'b1;
    clr_counts();
    #2;
    chk("rst_level", 32'(level), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_any", 32'(any_pulse), 0);
    tick_n(3);
    rst = 1'b0;
    tick_n(3);
    clr_counts();

    // press and release on channel 0
    in_raw[0] = 1'b1;
    tick_n(17);
    chk("t1_level_edge17", 32'(level[0]), 0);
    tick();
    chk("t1_level_edge18", 32'(level), 32'h01);
    chk("t1_pulse", 32'(pulse), 32'h01);
    chk("t1_any", 32'(any_pulse), 1);
    tick();
    chk("t1_pulse_once", 32'(pulse), 0);
    chk("t1_any_once", 32'(any_pulse), 0);
    tick_n(21);
    in_raw[0] = 1'b0;
    clr_counts();
    tick_n(17);
    chk("t1_rel_level17", 32'(level[0]), 1);
    tick();
    chk("t1_rel_level18", 32'(level[0]), 0);
    chk("t1_rel_nopulse", 32'(pcnt[0]), 0);

    // short bounce then a just-long-enough press on channel 2
    clr_counts();
    in_raw[2] = 1'b1;
    tick_n(10);
    in_raw[2] = 1'b0;
    tick_n(30);
    chk("t2_bounce_level", 32'(lvl2_seen), 0);
    chk("t2_bounce_pulse", 32'(pcnt[2]), 0);
    in_raw[2] = 1'b1;
    tick_n(17);
    in_raw[2] = 1'b0;
    tick_n(40);
    chk("t2_press17_pulses", 32'(pcnt[2]), 1);
    chk("t2_press17_level", 32'(level[2]), 0);

    // both-edges instance: press 30 cycles
    start2 = cyc;
    in_raw2[0] = 1'b1;
    tick_n(30);
    in_raw2[0] = 1'b0;
    tick_n(40);
    chk("t3_pulse_count", 32'(p2cnt), 2);
    chk("t3_first_at", 32'(p2first - start2), 18);
    chk("t3_spacing", 32'(p2second - p2first), 30);

    // enable gating, then simultaneous press
    clr_counts();
    enable = 1'b0;
    in_raw[1] = 1'b1;
    tick_n(20);
    chk("t4_level_dis", 32'(level[1]), 1);
    enable = 1'b1;
    tick_n(5);
    chk("t4_no_pulse", 32'(pcnt[1]), 0);
    in_raw[1] = 1'b0;
    tick_n(25);
    chk("t4_released", 32'(level[1]), 0);
    in_raw[1] = 1'b1;
    in_raw[3] = 1'b1;
    tick_n(17);
    chk("t4_pre_pulse", 32'(pulse), 0);
    tick();
    chk("t4_pulse_both", 32'(pulse), 32'h0A);
    chk("t4_any_both", 32'(any_pulse), 1);
    tick();
    chk("t4_pulse_after", 32'(pulse), 0);
    chk("t4_any_after", 32'(any_pulse), 0);
    in_raw[1] = 1'b0;
    in_raw[3] = 1'b0;
    tick_n(25);

    // long hold on channel 4
    in_raw[4] = 1'b1;
    tick_n(18);
    chk("t5_pulse_T", 32'(pulse[4]), 1);
    clr_counts();
    tick_n(49);
    chk("t5_quiet_to_49", 32'(pcnt[4]), 0);
    tick();
    chk("t5_pulse_T50", 32'(pulse[4]), 32'(RPT));
    tick_n(50);
    chk("t5_count_to_100", 32'(pcnt[4]), RPT ? 6 : 0);
    clr_counts();
    in_raw[4] = 1'b0;
    tick_n(30);
    chk("t5_after_release", 32'(pcnt[4]), RPT ? 1 : 0);
    chk("t5_level_rel", 32'(level[4]), 0);

    // reset mid-debounce
    in_raw[3] = 1'b1;
    tick_n(18);
    chk("t6_ch3_pulse", 32'(pulse), 32'h08);
    in_raw[0] = 1'b1;
    tick_n(10);
    chk("t6_pre_rst_level", 32'(level), 32'h08);
    rst = 1'b1;
    #1;
    chk("t6_async_level", 32'(level), 0);
    chk("t6_async_any", 32'(any_pulse), 0);
    tick_n(2);
    rst = 1'b0;
    clr_counts();
    tick_n(17);
    chk("t6_no_carry_level", 32'(level), 0);
    chk("t6_no_carry_pulse", 32'(pcnt[0] + pcnt[3]), 0);
    tick();
    chk("t6_level_18", 32'(level), 32'h09);
    chk("t6_pulse_18", 32'(pulse), 32'h09);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
